// File: rtl/dr_sync_fifo.sv
// dr_sync_fifo: dual-rail (two-phase "TP" or four-phase "FP") link receiver feeding a FWFT FIFO.
// Define DR_SYNC_ERR_EN to build the sticky illegal-code flag on err; otherwise err is tied low.
module dr_sync_fifo #(
  parameter string       ENC         = "TP",
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0][1:0]      in,
  output logic                       ack_o,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0]                       s1, s0;
  logic [WIDTH-1:0]                       word_data;
  logic                                   word_cmpl;
  logic                                   full, push, pop;
  logic                                   ack_q;
`ifdef DR_SYNC_ERR_EN
  logic                                   illegal;
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser; only the last stage is decoded
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  always_comb begin
    s1 = '0;
    s0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1[i] = sync_q[SYNC_STAGES-1][i][1];
      s0[i] = sync_q[SYNC_STAGES-1][i][0];
    end
  end

  // ---------------------------------------------------------------------------
  // Link decoder
  // ---------------------------------------------------------------------------
  if (ENC == "FP") begin : g_fp
    typedef enum logic {StIdle, StAck} fp_state_e;

    fp_state_e state_q;
    logic      spacer;

    assign word_data = s1;
    assign spacer    = ~|(s1 | s0);
    // Only a fresh code word seen while idle may be pushed; 11 is never complete
    assign word_cmpl = (state_q == StIdle) && (&(s1 ^ s0));
`ifdef DR_SYNC_ERR_EN
    assign illegal   = |(s1 & s0);
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        ack_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (push) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
            end
          end
          StAck: begin
            if (spacer) begin
              state_q <= StIdle;
              ack_q   <= 1'b0;
            end
          end
        endcase
      end
    end
  end else begin : g_tp
    logic [WIDTH-1:0] ref1_q, ref0_q;
    logic [WIDTH-1:0] chg1, chg0;

    assign chg1      = s1 ^ ref1_q;
    assign chg0      = s0 ^ ref0_q;
    assign word_data = chg1;
    // A bit is complete only when exactly one of its rails has toggled
    assign word_cmpl = &(chg1 ^ chg0);
`ifdef DR_SYNC_ERR_EN
    assign illegal   = |(chg1 & chg0);
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        ref1_q <= '0;
        ref0_q <= '0;
        ack_q  <= 1'b0;
      end else if (push) begin
        ref1_q <= s1;
        ref0_q <= s0;
        ack_q  <= ~ack_q;
      end
    end
  end

  assign ack_o = ack_q;

  // ---------------------------------------------------------------------------
  // Sticky illegal-code flag
  // ---------------------------------------------------------------------------
`ifdef DR_SYNC_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO with a registered head
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q;

  assign full = (count_q == CntW'(DEPTH));
  assign push = word_cmpl & ~full;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    rptr_d  = rptr_q + PtrW'(pop);
    count_d = count_q + CntW'(push) - CntW'(pop);
    // Entries older than this cycle's push; a fresh push shows up one cycle later
    out_valid_d = (count_q != CntW'(pop));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= word_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_data_q <= mem_q[rptr_d];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dr_sync_fifo.sv
// Bench for dr_sync_fifo: one FP and one TP instance driven by a protocol-level sender model
// and checked against a queue-based FIFO reference.
module tb_dr_sync_fifo;

  localparam int unsigned W     = 8;
  localparam int unsigned D     = 4;
  localparam int unsigned Lat   = 3;  // sync stages + decode edge
`ifdef DR_SYNC_ERR_EN
  localparam bit          ErrEn = 1'b1;
`else
  localparam bit          ErrEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [W-1:0][1:0]   rails_fp, rails_tp;
  logic                ack_fp, ack_tp;
  logic [W-1:0]        data_fp, data_tp;
  logic                valid_fp, valid_tp;
  logic                ready_fp, ready_tp;
  logic [2:0]          count_fp, count_tp;
  logic                err_fp, err_tp;

  always #5 clk = ~clk;

  dr_sync_fifo #(.ENC("FP"), .WIDTH(W), .DEPTH(D), .SYNC_STAGES(2)) u_fp (
    .clk(clk), .rst(rst), .in(rails_fp), .ack_o(ack_fp), .out_data(data_fp),
    .out_valid(valid_fp), .out_ready(ready_fp), .count(count_fp), .err(err_fp)
  );

  dr_sync_fifo #(.ENC("TP"), .WIDTH(W), .DEPTH(D), .SYNC_STAGES(2)) u_tp (
    .clk(clk), .rst(rst), .in(rails_tp), .ack_o(ack_tp), .out_data(data_tp),
    .out_valid(valid_tp), .out_ready(ready_tp), .count(count_tp), .err(err_tp)
  );

  int unsigned       n_checks = 0;
  int unsigned       n_fails  = 0;
  logic [W-1:0]      mq[$];          // words accepted by the active instance, oldest first
  logic [W-1:0][1:0] tp_ref_m;       // rails at the last accepted TP word
  logic              tp_ack_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_valid(input bit tp);
    return tp ? valid_tp : valid_fp;
  endfunction

  function automatic logic [W-1:0] get_data(input bit tp);
    return tp ? data_tp : data_fp;
  endfunction

  function automatic logic [2:0] get_count(input bit tp);
    return tp ? count_tp : count_fp;
  endfunction

  function automatic logic [W-1:0][1:0] fp_code(input logic [W-1:0] w);
    logic [W-1:0][1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  // Send one FP word into a FIFO known to have room; ack is expected exactly Lat cycles later
  task automatic fp_send(input logic [W-1:0] w);
    rails_fp = fp_code(w);
    repeat (Lat - 1) tick();
    check_eq("fp_ack_early", ack_fp, 0);
    tick();
    mq.push_back(w);
    check_eq("fp_ack_rise", ack_fp, 1);
    check_eq("fp_count_push", count_fp, mq.size());
  endtask

  task automatic fp_spacer();
    rails_fp = '0;
    repeat (Lat - 1) tick();
    check_eq("fp_ack_hold", ack_fp, 1);
    tick();
    check_eq("fp_ack_fall", ack_fp, 0);
  endtask

  task automatic tp_send(input logic [W-1:0] w);
    logic [W-1:0][1:0] r;
    for (int i = 0; i < W; i++) r[i] = tp_ref_m[i] ^ (w[i] ? 2'b10 : 2'b01);
    rails_tp = r;
    repeat (Lat - 1) tick();
    check_eq("tp_ack_early", ack_tp, tp_ack_m);
    tick();
    tp_ack_m = ~tp_ack_m;
    tp_ref_m = r;
    mq.push_back(w);
    check_eq("tp_ack_toggle", ack_tp, tp_ack_m);
    check_eq("tp_count_push", count_tp, mq.size());
  endtask

  // Random-ready drain of the active instance, scoreboarded against mq
  task automatic drain(input bit tp);
    int n;
    bit rdy;
    n = 0;
    tick();
    while (mq.size() != 0 && n < 200) begin
      rdy = 1'($urandom_range(0, 1));
      if (tp) ready_tp = rdy;
      else ready_fp = rdy;
      check_eq("head_valid", get_valid(tp), 1);
      check_eq("head_data", get_data(tp), mq[0]);
      check_eq("occupancy", get_count(tp), mq.size());
      tick();
      if (rdy) void'(mq.pop_front());
      n++;
    end
    ready_fp = 1'b0;
    ready_tp = 1'b0;
    check_eq("drain_valid", get_valid(tp), 0);
    check_eq("drain_count", get_count(tp), 0);
  endtask

  initial begin
    logic [W-1:0]      w;
    logic [W-1:0]      last_w;
    logic [W-1:0][1:0] r;

    rst      = 1'b1;
    rails_fp = '0;
    rails_tp = '0;
    ready_fp = 1'b0;
    ready_tp = 1'b0;
    tp_ref_m = '0;
    tp_ack_m = 1'b0;
    repeat (3) tick();
    check_eq("rst_ack_fp", ack_fp, 0);
    check_eq("rst_valid_fp", valid_fp, 0);
    check_eq("rst_count_fp", count_fp, 0);
    check_eq("rst_err_fp", err_fp, 0);
    check_eq("rst_ack_tp", ack_tp, 0);
    check_eq("rst_valid_tp", valid_tp, 0);
    check_eq("rst_count_tp", count_tp, 0);
    check_eq("rst_err_tp", err_tp, 0);
    rst = 1'b0;
    tick();

    // FP single word: head appears one cycle after the push, stays until popped
    fp_send(8'hA5);
    check_eq("fp_valid_lag", valid_fp, 0);
    tick();
    check_eq("fp_valid", valid_fp, 1);
    check_eq("fp_head", data_fp, 8'hA5);
    fp_spacer();
    check_eq("fp_count_held", count_fp, 1);
    check_eq("fp_head_held", data_fp, 8'hA5);
    drain(1'b0);

    // TP two directed words plus random ones
    tp_send(8'h3C);
    tp_send(8'hC3);
    check_eq("tp_ack_back", ack_tp, 0);
    tp_send(8'($urandom_range(0, 255)));
    tp_send(8'($urandom_range(0, 255)));
    drain(1'b1);

    // FP full FIFO: fifth word is held without ack until one pop frees space
    for (int k = 0; k < 4; k++) begin
      fp_send(8'($urandom_range(0, 255)));
      fp_spacer();
    end
    last_w   = 8'($urandom_range(0, 255));
    rails_fp = fp_code(last_w);
    repeat (Lat + 4) tick();
    check_eq("full_ack_withheld", ack_fp, 0);
    check_eq("full_count", count_fp, D);
    check_eq("full_head", data_fp, mq[0]);
    ready_fp = 1'b1;
    tick();
    ready_fp = 1'b0;
    void'(mq.pop_front());
    check_eq("pop_count", count_fp, 3);
    check_eq("pop_ack_still0", ack_fp, 0);
    tick();
    mq.push_back(last_w);
    check_eq("late_ack", ack_fp, 1);
    check_eq("late_count", count_fp, D);
    fp_spacer();
    drain(1'b0);

    // Partial word: bit 7 left at spacer for 20 cycles
    w = 8'($urandom_range(0, 255));
    r = fp_code(w);
    r[7] = 2'b00;
    rails_fp = r;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("partial_ack", ack_fp, 0);
      check_eq("partial_count", count_fp, 0);
    end
    fp_send(w);
    fp_spacer();
    drain(1'b0);

    // Randomised bursts on both encodings
    for (int round = 0; round < 6; round++) begin
      int unsigned nw;
      nw = $urandom_range(1, D);
      for (int k = 0; k < int'(nw); k++) begin
        w = 8'($urandom_range(0, 255));
        if (round[0]) begin
          tp_send(w);
        end else begin
          fp_send(w);
          fp_spacer();
        end
      end
      drain(round[0]);
    end

    // Reset while FP sits in its ack phase with two words stored
    fp_send(8'h11);
    fp_spacer();
    fp_send(8'h22);
    check_eq("pre_rst_count", count_fp, 2);
    rst      = 1'b1;
    rails_fp = '0;
    rails_tp = '0;
    tick();
    check_eq("midrst_ack", ack_fp, 0);
    check_eq("midrst_count", count_fp, 0);
    check_eq("midrst_valid", valid_fp, 0);
    rst = 1'b0;
    mq.delete();
    tp_ref_m = '0;
    tp_ack_m = 1'b0;
    tick();
    fp_send(8'h5A);
    fp_spacer();
    drain(1'b0);

    // Illegal codes: FP 11 on bit 3, TP both rails of bit 0 toggled
    r = fp_code(8'($urandom_range(0, 255)));
    r[3] = 2'b11;
    rails_fp = r;
    r = tp_ref_m;
    r[0] = r[0] ^ 2'b11;
    for (int i = 1; i < W; i++) r[i] = r[i] ^ 2'b01;
    rails_tp = r;
    repeat (Lat + 1) tick();
    check_eq("fp_err", err_fp, ErrEn);
    check_eq("fp_err_noack", ack_fp, 0);
    check_eq("fp_err_nopush", count_fp, 0);
    check_eq("tp_err", err_tp, ErrEn);
    check_eq("tp_err_noack", ack_tp, tp_ack_m);
    check_eq("tp_err_nopush", count_tp, 0);
    repeat (5) tick();
    check_eq("fp_err_sticky", err_fp, ErrEn);
    check_eq("tp_err_sticky", err_tp, ErrEn);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
